// File: rtl/usb_arb_pkg.sv
// Shared definitions for the USB transmit arbiter: FSM encoding and tag byte base.
package usb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hF0;

endpackage

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Round-robin picker: one-hot select of the first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    always_comb begin
        logic [IDX_W:0] j;
        logic           found;
        pick  = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (j >= (IDX_W+1)'(NUM_REQ)) begin
                j = j - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[j[IDX_W-1:0]]) begin
                pick[j[IDX_W-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin byte-stream arbiter feeding the USB serial transmit FIFO.
// Optional tag byte per grant is compiled in with USB_TX_ARBITER_TAG_EN.
module usb_tx_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           out_data,
    output logic                 out_strobe,
    input  logic                 out_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [1:0]           dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   g_idx, g_idx_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [7:0]         count, count_n;
    logic               strobe_n;
    logic [7:0]         data_n;

    logic [NUM_REQ-1:0] pick;
    logic               any;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         cur_data;
    logic               cur_valid;
    logic               cur_last;
    logic               hs;
    logic [8:0]         cnt_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (any)
    );

    always_comb begin
        pick_idx = '0;
        cur_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
            if (g_idx == IDX_W'(i)) cur_data = req_data[8*i +: 8];
        end
    end

    assign cur_valid = req_valid[g_idx];
    assign cur_last  = req_last[g_idx];

    // Handshake: a byte moves from requester g when req_valid[g] && req_ready[g] at a
    // rising edge; req_ready is only ever raised for the owner in DATA and follows
    // out_ready combinationally, so the FIFO always has room for the registered write.
    assign req_ready = (state == DATA) ? (grant & {NUM_REQ{out_ready}}) : '0;
    assign hs        = (state == DATA) && cur_valid && out_ready;
    assign cnt_inc   = {1'b0, count} + 9'd1;
    assign dbg_state = state;

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        g_idx_n  = g_idx;
        grant_n  = grant;
        count_n  = count;
        strobe_n = 1'b0;
        data_n   = out_data;
        case (state)
            IDLE: begin
                if (any) begin
                    grant_n  = pick;
                    g_idx_n  = pick_idx;
                    rr_ptr_n = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                    count_n  = 8'h00;
`ifdef USB_TX_ARBITER_TAG_EN
                    state_n  = TAG;
`else
                    state_n  = DATA;
`endif
                end
            end
`ifdef USB_TX_ARBITER_TAG_EN
            TAG: begin
                if (out_ready) begin
                    strobe_n = 1'b1;
                    data_n   = TAG_BASE | 8'(g_idx);
                    state_n  = DATA;
                end
            end
`endif
            DATA: begin
                if (hs) begin
                    strobe_n = 1'b1;
                    data_n   = cur_data;
                    count_n  = cnt_inc[7:0];
                    // End of frame and burst cut behave identically: release and re-arbitrate.
                    if (cur_last || cnt_inc == 9'(MAX_BURST)) begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g_idx      <= '0;
            grant      <= '0;
            count      <= 8'h00;
            out_strobe <= 1'b0;
            out_data   <= 8'h00;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            g_idx      <= g_idx_n;
            grant      <= grant_n;
            count      <= count_n;
            out_strobe <= strobe_n;
            out_data   <= data_n;
        end
    end

endmodule
